// File: rtl/fp_pkg.sv
// Shared single-precision field constants and converter FSM states.
// Also used by the FP adder and the CNN accumulation blocks.
package fp_pkg;

  localparam int unsigned FP_BIAS  = 127;
  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 23;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } fp_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized 24-bit significand window.
// The fraction carry-out bumps the exponent; the fraction itself wraps to zero.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP_MAN_W:0]   sig,
  input  logic                guard,
  input  logic                sticky,
  input  logic [FP_EXP_W-1:0] exp_in,
  output logic [FP_MAN_W-1:0] frac,
  output logic [FP_EXP_W-1:0] exp_out
);

  logic            round_up;
  logic [FP_MAN_W:0] sum;

  always_comb begin
    // An unnormalized window (hidden bit clear) is never rounded.
    round_up = sig[FP_MAN_W] & guard & (sticky | sig[0]);
    sum      = {1'b0, sig[FP_MAN_W-1:0]} + {{FP_MAN_W{1'b0}}, round_up};
    frac     = sum[FP_MAN_W-1:0];
    exp_out  = exp_in + {{(FP_EXP_W-1){1'b0}}, sum[FP_MAN_W]};
  end

endmodule

// File: rtl/int_to_fp.sv
// Signed integer to IEEE-754 single precision fields, normalizing one bit per clock
// and rounding to nearest even. Valid/ready on both sides, one conversion in flight.
module int_to_fp
  import fp_pkg::*;
#(
  parameter int unsigned INT_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INT_W-1:0]    in_int,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sign,
  output logic [FP_EXP_W-1:0] exponent,
  output logic [FP_MAN_W-1:0] mantissa
);

  localparam logic [FP_EXP_W-1:0] ExpInit    = FP_EXP_W'(FP_BIAS + INT_W - 1);
  // Bits below the guard position feed the sticky bit; empty when INT_W is 25.
  localparam logic [INT_W-1:0]    StickyMask = {INT_W{1'b1}} >> 25;

  fp_state_e             state_q, state_d;
  logic [INT_W-1:0]      mag_q, mag_d;
  logic [FP_EXP_W-1:0]   e_q, e_d;
  logic                  s_q, s_d;
  logic                  sign_q, sign_d;
  logic [FP_EXP_W-1:0]   exp_q, exp_d;
  logic [FP_MAN_W-1:0]   man_q, man_d;

  logic [INT_W-1:0]      in_mag;
  logic [FP_MAN_W-1:0]   rnd_frac;
  logic [FP_EXP_W-1:0]   rnd_exp;

  // Most negative input negates to itself, which is the correct unsigned magnitude.
  assign in_mag = in_int[INT_W-1] ? (INT_W'(0) - in_int) : in_int;

  fp_round_rne u_round (
    .sig     (mag_q[INT_W-1 -: FP_MAN_W+1]),
    .guard   (mag_q[INT_W-25]),
    .sticky  (|(mag_q & StickyMask)),
    .exp_in  (e_q),
    .frac    (rnd_frac),
    .exp_out (rnd_exp)
  );

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    e_d     = e_q;
    s_d     = s_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    man_d   = man_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_int[INT_W-1];
          mag_d   = in_mag;
          e_d     = ExpInit;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          sign_d  = 1'b0;
          exp_d   = '0;
          man_d   = '0;
          state_d = DONE;
        end else if (!mag_q[INT_W-1]) begin
          mag_d = mag_q << 1;
          e_d   = e_q - FP_EXP_W'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        sign_d  = s_q;
        exp_d   = rnd_exp;
        man_d   = rnd_frac;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      e_q     <= e_d;
      s_q     <= s_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sign      = sign_q;
  assign exponent  = exp_q;
  assign mantissa  = man_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Directed bench for int_to_fp: arithmetic reference model plus literal results,
// latency, backpressure and asynchronous reset abort.
module tb_int_to_fp;

  localparam int unsigned INT_W = 32;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_int    = '0;
  logic        in_ready;
  logic        out_valid;
  logic        sign;
  logic [7:0]  exponent;
  logic [22:0] mantissa;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_word = '0;

  int_to_fp #(.INT_W(INT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_int    (in_int),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .exponent  (exponent),
    .mantissa  (mantissa)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: locate the leading one arithmetically and round the quotient
  // to nearest even by comparing the remainder against one half.
  function automatic logic [31:0] model(input logic [31:0] x, output int lat);
    longint m, q, rem, half;
    int     p, e;
    bit     s;
    s = x[31];
    m = longint'($signed(x));
    if (m < 0) m = -m;
    if (m == 0) begin
      lat = 1;
      return 32'h0;
    end
    p = 0;
    for (int i = 0; i < 62; i++) if (m >= (longint'(1) << i)) p = i;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      q    = m >> (p - 23);
      rem  = m - (q << (p - 23));
      half = longint'(1) << (p - 24);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    lat = (INT_W - 1 - p) + 2;
    return {s, 8'(e), q[22:0]};
  endfunction

  // Every cycle a result is presented it must match the model and block new input.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      check("model_fields", {sign, exponent, mantissa}, exp_word);
      check("in_ready_busy", in_ready, 1'b0);
    end
  end

  task automatic convert(input logic [31:0] x, input logic [31:0] lit, input int hold,
                         input bit early);
    int lat_exp;
    int k;
    exp_word = model(x, lat_exp);
    @(negedge clock);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_int    = x;
    out_ready = early;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_int   = $urandom;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("latency", 64'(k), 64'(lat_exp));
    check("literal_result", {sign, exponent, mantissa}, lit);
    if (early) begin
      @(posedge clock);
      #1;
      check("early_ready_handshake", out_valid, 1'b0);
    end else begin
      repeat (hold) begin
        @(negedge clock);
        in_valid = 1'b1;
        in_int   = $urandom;
      end
      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      check("release_out_valid", out_valid, 1'b0);
    end
    check("release_in_ready", in_ready, 1'b1);
    check("fields_hold", {sign, exponent, mantissa}, exp_word);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_fields", {sign, exponent, mantissa}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    convert(32'h0000_0001, 32'h3F80_0000, 0, 1'b0);
    convert(32'hFFFF_FFFF, 32'hBF80_0000, 0, 1'b0);
    convert(32'h0000_0000, 32'h0000_0000, 0, 1'b0);
    convert(32'h8000_0000, 32'hCF00_0000, 0, 1'b0);
    convert(32'h7FFF_FFFF, 32'h4F00_0000, 0, 1'b0);
    convert(32'd16777217,  32'h4B80_0000, 0, 1'b1);
    convert(32'd16777219,  32'h4B80_0002, 0, 1'b0);
    convert(32'd16777221,  32'h4B80_0002, 0, 1'b0);
    convert(32'hFFFF_FF9C, 32'hC2C8_0000, 5, 1'b0);
    convert(32'd100,       32'h42C8_0000, 2, 1'b0);

    // Abort a conversion of 1 partway through normalization.
    @(negedge clock);
    in_valid = 1'b1;
    in_int   = 32'h1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_fields", {sign, exponent, mantissa}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    convert(32'h0000_0003, 32'h4040_0000, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
